// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  // Controller states; the encoding is visible on the debug state signal.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_t;

  // Register x0 is hard-wired to zero, so it never creates a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the memory wait/timeout counter.
  localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request handshake between the hazard controller and memory.
// Handshake rules: the controller holds mem_req_valid high for as long as a
// request is pending; the request is taken in the first cycle where
// mem_req_valid and mem_req_ready are both high. mem_rsp_valid is a
// one-cycle completion strobe and may coincide with the accepting cycle.
// dbg_state mirrors the controller state for observation only.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic   mem_req_valid;
  logic   mem_req_ready;
  logic   mem_rsp_valid;
  state_t dbg_state;

  modport master (
    output mem_req_valid,
    output dbg_state,
    input  mem_req_ready,
    input  mem_rsp_valid
  );

  modport slave (
    input  mem_req_valid,
    input  dbg_state,
    output mem_req_ready,
    output mem_rsp_valid
  );
endinterface

// File: rtl/mem_hs_fsm.sv
// Data-memory handshake FSM: owns the IDLE/REQ/WAIT/HALT state register,
// the registered request strobe and the WAIT timeout counter. It reports
// freeze, release and timeout to the top; the halt request comes from above.
module mem_hs_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   halt_req,
  input  logic   mem_req_ready,
  input  logic   mem_rsp_valid,
  output state_t state_o,
  output logic   freeze,
  output logic   mem_release,
  output logic   timeout,
  output logic   mem_req_valid,
  output logic   halted
);

  localparam state_t                RST_STATE   = RESET_HALTED ? HALT : IDLE;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 mem_req_q, mem_req_d;
  logic                 halted_q, halted_d;

  // Decode freeze/release/timeout for the current cycle and advance the wait counter.
  always_comb begin
    freeze      = 1'b0;
    mem_release = 1'b0;
    timeout     = 1'b0;
    wait_cnt_d  = '0;
    unique case (state_q)
      IDLE: freeze = start;
      REQ: begin
        mem_release = mem_req_ready & mem_rsp_valid;
        freeze      = ~mem_release;
      end
      WAIT: begin
        mem_release = mem_rsp_valid;
        freeze      = ~mem_release;
        wait_cnt_d  = wait_cnt_q + TIMEOUT_W'(1);
        // A response arriving on the last allowed cycle still wins.
        timeout     = ~mem_rsp_valid & (wait_cnt_d == TIMEOUT_LIM);
      end
      default: freeze = 1'b1;
    endcase
  end

  // Next state; a halt request overrides everything, dropping any outstanding access.
  always_comb begin
    state_d = state_q;
    if (halt_req) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = REQ;
        REQ:  if (mem_req_ready) state_d = mem_rsp_valid ? IDLE : WAIT;
        WAIT: begin
          if (mem_rsp_valid) state_d = IDLE;
          else if (timeout)  state_d = HALT;
        end
        default: state_d = HALT;
      endcase
    end
    mem_req_d = (state_d == REQ);
    halted_d  = (state_d == HALT);
  end

  // State register with registered request/halt outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      wait_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      halted_q   <= RESET_HALTED;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_req_q  <= mem_req_d;
      halted_q   <= halted_d;
    end
  end

  assign state_o       = state_q;
  assign mem_req_valid = mem_req_q;
  assign halted        = halted_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: stage load
// enables, flush/bubble strobes, load-use and branch handling, memory freeze
// and ebreak halt. Optional performance counters: define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        reg_ren_D,
  input  logic [4:0]  rd_E,
  input  logic        MemRead_E,
  input  logic        PCSrc_E,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic        ebreak_W,
  pipe_hazard_ctrl_if.master mem,
  output logic        valid_F,
  output logic        valid_D,
  output logic        valid_E,
  output logic        valid_M,
  output logic        flush_D,
  output logic        bubble_E,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  state_t state;
  logic   mem_op_M, load_use;
  logic   freeze, mem_release, timeout, fsm_halted, fsm_req;
  logic   mem_err_q, mem_err_d;

  assign mem_op_M = MemRead_M | MemWrite_M;
  assign load_use = MemRead_E & (rd_E != REG_X0) & reg_ren_D &
                    ((rs1_D == rd_E) | (rs2_D == rd_E));

  mem_hs_fsm #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .RESET_HALTED (RESET_HALTED)
  ) u_mem_hs (
    .clk           (clk),
    .rst           (rst),
    .start         (mem_op_M),
    .halt_req      (ebreak_W),
    .mem_req_ready (mem.mem_req_ready),
    .mem_rsp_valid (mem.mem_rsp_valid),
    .state_o       (state),
    .freeze        (freeze),
    .mem_release   (mem_release),
    .timeout       (timeout),
    .mem_req_valid (fsm_req),
    .halted        (fsm_halted)
  );

  assign mem.mem_req_valid = fsm_req;
  assign mem.dbg_state     = state;
  assign halted            = fsm_halted & ~rst;
  assign mem_err           = mem_err_q;

  // Stage enables: halt, then memory freeze/release, then branch over load-use.
  always_comb begin
    valid_F  = 1'b0;
    valid_D  = 1'b0;
    valid_E  = 1'b0;
    valid_M  = 1'b0;
    flush_D  = 1'b0;
    bubble_E = 1'b0;
    if (rst || state == HALT || freeze) begin
      // everything held; hazards in D/E are masked until release
    end else if (mem_release) begin
      {valid_F, valid_D, valid_E, valid_M} = 4'hF;
    end else if (PCSrc_E) begin
      {valid_F, valid_D, valid_E, valid_M} = 4'hF;
      flush_D  = 1'b1;
      bubble_E = 1'b1;
    end else if (load_use) begin
      {valid_F, valid_D, valid_E, valid_M} = 4'b0111;
      bubble_E = 1'b1;
    end else begin
      {valid_F, valid_D, valid_E, valid_M} = 4'hF;
    end
  end

  // Memory timeout is sticky until reset.
  always_comb begin
    mem_err_d = mem_err_q | timeout;
  end

  // Sticky error flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_err_q <= 1'b0;
    else     mem_err_q <= mem_err_d;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Count fetch-stall cycles outside HALT and flush strobes; both wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q + ((~valid_F && state != HALT) ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flush_D ? 32'd1 : 32'd0);
  end

  // Performance counter flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus, checked against a behavioural model of the controller rules.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int W = 73;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  rs1_D, rs2_D, rd_E;
  logic        reg_ren_D, MemRead_E, PCSrc_E, MemRead_M, MemWrite_M, ebreak_W;
  logic        valid_F, valid_D, valid_E, valid_M, flush_D, bubble_E, halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl_if mem_bus();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .RESET_HALTED (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_D      (rs1_D),
    .rs2_D      (rs2_D),
    .reg_ren_D  (reg_ren_D),
    .rd_E       (rd_E),
    .MemRead_E  (MemRead_E),
    .PCSrc_E    (PCSrc_E),
    .MemRead_M  (MemRead_M),
    .MemWrite_M (MemWrite_M),
    .ebreak_W   (ebreak_W),
    .mem        (mem_bus),
    .valid_F    (valid_F),
    .valid_D    (valid_D),
    .valid_E    (valid_E),
    .valid_M    (valid_M),
    .flush_D    (flush_D),
    .bubble_E   (bubble_E),
    .halted     (halted),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ren;
    logic       ld_e;
    logic       br;
    logic       ld_m;
    logic       st_m;
    logic       ebrk;
    logic       rdy;
    logic       rsp;
  } stim_t;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Abstract view: is the core halted, is a memory op outstanding, has the
  // request been accepted yet, how many cycles it has been waiting.
  bit          m_halted, m_busy, m_accepted, m_err;
  int          m_waits;
  logic [31:0] m_stall, m_flush;

  task automatic model_reset();
    m_halted = 1'b0; m_busy = 1'b0; m_accepted = 1'b0; m_err = 1'b0;
    m_waits = 0; m_stall = '0; m_flush = '0;
  endtask

  task automatic model_step(input stim_t s);
    logic [3:0]  v;
    logic        fl, bb, req, lu;
    logic [63:0] cnts;
    v = 4'h0; fl = 1'b0; bb = 1'b0; req = 1'b0;
    lu = s.ld_e && (s.rd != 5'd0) && s.ren && (s.rs1 == s.rd || s.rs2 == s.rd);
    if (m_halted) begin
      v = 4'h0;
    end else if (!m_busy) begin
      if (s.ld_m || s.st_m) v = 4'h0;
      else if (s.br) begin v = 4'hF; fl = 1'b1; bb = 1'b1; end
      else if (lu)   begin v = 4'b0111; bb = 1'b1; end
      else           v = 4'hF;
    end else begin
      req = !m_accepted;
      v   = {4{m_accepted ? s.rsp : (s.rdy && s.rsp)}};
    end
`ifdef PIPE_PERF_CNT_EN
    cnts = {m_stall, m_flush};
    if (!v[3] && !m_halted) m_stall = m_stall + 32'd1;
    if (fl) m_flush = m_flush + 32'd1;
`else
    cnts = 64'd0;
`endif
    exp_q.push_back({v, fl, bb, req, m_halted, m_err, cnts});
    // state evolution
    if (!m_halted && m_busy && m_accepted && !s.rsp && (m_waits + 1 == MEM_TIMEOUT))
      m_err = 1'b1;
    if (s.ebrk) begin
      m_halted = 1'b1;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (!m_busy) begin
      if (s.ld_m || s.st_m) begin m_busy = 1'b1; m_accepted = 1'b0; end
    end else if (!m_accepted) begin
      if (s.rdy && s.rsp) m_busy = 1'b0;
      else if (s.rdy) begin m_accepted = 1'b1; m_waits = 0; end
    end else if (s.rsp) begin
      m_busy = 1'b0;
    end else begin
      m_waits++;
      if (m_waits == MEM_TIMEOUT) m_halted = 1'b1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {valid_F, valid_D, valid_E, valid_M, flush_D, bubble_E,
               mem_bus.mem_req_valid, halted, mem_err, stall_cnt, flush_cnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t: got vF/vD/vE/vM/fl/bb/req/hlt/err=%b cnt=%h, expected %b cnt=%h",
                 $time, act_v[72:64], act_v[63:0], exp_v[72:64], exp_v[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input stim_t s);
    rs1_D = s.rs1; rs2_D = s.rs2; rd_E = s.rd; reg_ren_D = s.ren;
    MemRead_E = s.ld_e; PCSrc_E = s.br; MemRead_M = s.ld_m; MemWrite_M = s.st_m;
    ebreak_W = s.ebrk; mem_bus.mem_req_ready = s.rdy; mem_bus.mem_rsp_valid = s.rsp;
  endtask

  // Called at posedge+1; drives one cycle of stimulus and records the expectation.
  task automatic step(input stim_t s);
    apply(s);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [9:0] act_v;
    act_v = {valid_F, valid_D, valid_E, valid_M, flush_D, bubble_E,
             mem_bus.mem_req_valid, halted, mem_err, (stall_cnt | flush_cnt) != 32'd0};
    checks++;
    if (act_v !== 10'd0 || mem_bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL %s: got outputs=%b state=%0d, expected all 0 and state 0",
               tag, act_v, mem_bus.dbg_state);
    end
  endtask

  // Asynchronous reset pulse asserted mid-cycle with hazard-provoking inputs.
  task automatic do_reset();
    stim_t s;
    s = '0; s.br = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.ld_e = 1'b1; s.ren = 1'b1;
    apply(s);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(posedge clk);
    #1 check_reset_outputs("reset_held");
    rst = 1'b0;
    model_reset();
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1  = 5'($urandom_range(0, 3));
    s.rs2  = 5'($urandom_range(0, 3));
    s.rd   = 5'($urandom_range(0, 3));
    s.ren  = ($urandom_range(0, 3) != 0);
    s.ld_e = ($urandom_range(0, 1) != 0);
    s.br   = ($urandom_range(0, 4) == 0);
    s.ld_m = ($urandom_range(0, 7) == 0);
    s.st_m = ($urandom_range(0, 7) == 0);
    s.ebrk = ($urandom_range(0, 59) == 0);
    s.rdy  = ($urandom_range(0, 1) != 0);
    s.rsp  = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    int halted_cycles;
    s = '0;
    apply(s);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_initial");
    rst = 1'b0;

    // no hazard
    s = '0; step(s);
    // load-use via rs1, then clean cycle
    s = '0; s.ld_e = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.ren = 1; step(s);
    s = '0; step(s);
    // load-use via rs2
    s = '0; s.ld_e = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.ren = 1; step(s);
    // rd = x0 is not a hazard
    s = '0; s.ld_e = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.ren = 1; step(s);
    // no register read, no hazard
    s = '0; s.ld_e = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.ren = 0; step(s);
    // branch beats load-use
    s = '0; s.br = 1; s.ld_e = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.ren = 1; step(s);

    // store: ready after 2 REQ cycles... then response 3 cycles after acceptance
    s = '0; s.st_m = 1; step(s);               // IDLE detect
    step(s);                                   // REQ, not ready
    s.rdy = 1; step(s);                        // REQ accepted
    s.rdy = 0; step(s); step(s);               // WAIT
    s.rsp = 1; step(s);                        // release
    s = '0; step(s); step(s);                  // next instruction, no reissue

    // same-cycle accept and response
    s = '0; s.ld_m = 1; step(s);
    s.rdy = 1; s.rsp = 1; step(s);
    s = '0; step(s);

    // timeout: response never comes
    s = '0; s.ld_m = 1; step(s);
    s.rdy = 1; step(s);
    s.rdy = 0; repeat (MEM_TIMEOUT) step(s);
    s = '0; repeat (3) step(s);                // halted, mem_err sticky
    do_reset();

    // ebreak while waiting: halt and drop the response
    s = '0; s.ld_m = 1; step(s);
    s.rdy = 1; step(s);
    s.rdy = 0; step(s);
    s.ebrk = 1; step(s);
    s = '0; s.rsp = 1; step(s); step(s);
    do_reset();

    // ebreak in IDLE
    s = '0; s.ebrk = 1; step(s);
    s = '0; step(s);
    do_reset();

    // random traffic, resetting a few cycles after the model halts
    halted_cycles = 0;
    for (int i = 0; i < 1500; i++) begin
      step(rand_stim());
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halted_cycles = 0;
      end
    end

    s = '0; apply(s);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
